// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, fixed latency,
// signed/unsigned operation with quotient, remainder and a condition-register field.
module div_iter #(
  parameter int DWIDTH          = 32,
  parameter bit REGISTER_RESULT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              uns,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic              ready,
  output logic              complete,
  output logic [DWIDTH-1:0] quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic [3:0]        crf
);

  localparam int CW = $clog2(DWIDTH);
  localparam logic [DWIDTH-1:0] MIN_INT = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic              ovf;
  logic [DWIDTH-1:0] divisor;
  logic [DWIDTH-1:0] dividend;
  logic [DWIDTH-1:0] prem;
  logic [DWIDTH-1:0] q_reg;
  logic [DWIDTH-1:0] r_reg;
  logic [3:0]        crf_reg;
  logic              complete_reg;

  logic              a_neg;
  logic              b_neg;
  logic [DWIDTH:0]   shifted;
  logic [DWIDTH:0]   trial;
  logic [DWIDTH-1:0] q_fix;
  logic [DWIDTH-1:0] r_fix;
  logic [3:0]        crf_fix;

  // The dividend register doubles as the quotient shift register during CALC.
  always_comb begin
    a_neg   = ~uns & a[DWIDTH-1];
    b_neg   = ~uns & b[DWIDTH-1];
    shifted = {prem, dividend[DWIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    q_fix   = neg_q ? -dividend : dividend;
    if (div_zero)
      q_fix = '0;
    r_fix   = neg_r ? -prem : prem;
    crf_fix = {q_fix[DWIDTH-1],
               ~q_fix[DWIDTH-1] & (q_fix != '0),
               (q_fix == '0),
               div_zero | ovf};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ready        <= 1'b1;
      complete_reg <= 1'b0;
      q_reg        <= '0;
      r_reg        <= '0;
      crf_reg      <= '0;
      count        <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      ovf          <= 1'b0;
      divisor      <= '0;
      dividend     <= '0;
      prem         <= '0;
    end else begin
      complete_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (b == '0);
            ovf      <= ~uns & (a == MIN_INT) & (&b);
            dividend <= a_neg ? -a : a;
            divisor  <= b_neg ? -b : b;
            prem     <= '0;
            count    <= CW'(DWIDTH - 1);
            ready    <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          // A borrow out of the DWIDTH+1 bit trial means restore the shifted value.
          prem     <= trial[DWIDTH] ? shifted[DWIDTH-1:0] : trial[DWIDTH-1:0];
          dividend <= {dividend[DWIDTH-2:0], ~trial[DWIDTH]};
          count    <= count - CW'(1);
          if (count == '0)
            state <= FIX;
        end
        FIX: begin
          q_reg   <= q_fix;
          r_reg   <= r_fix;
          crf_reg <= crf_fix;
          if (REGISTER_RESULT) begin
            complete_reg <= 1'b1;
            state        <= DONE;
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Without the result register, FIX drives the outputs directly for its single cycle.
  assign complete  = REGISTER_RESULT ? complete_reg : (state == FIX);
  assign quotient  = (!REGISTER_RESULT && state == FIX) ? q_fix   : q_reg;
  assign remainder = (!REGISTER_RESULT && state == FIX) ? r_fix   : r_reg;
  assign crf       = (!REGISTER_RESULT && state == FIX) ? crf_fix : crf_reg;

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 integer divider. It is the inverse-operation companion to the pipelined multiplier in the fixed-point unit and serves divw/divwu-class instructions.
- It accepts one operation when idle and computes one quotient bit per cycle. It returns the quotient, the remainder and a condition-register field with a fixed latency.
- It uses the same en/uns/ready/complete handshake style as the multiplier, so the frontend can issue to either unit identically.

Parameters:
- DWIDTH, 32 (Pu_types::DWIDTH): operand and result width.
- REGISTER_RESULT, 1: 1 registers quotient, remainder and crf in a DONE cycle; 0 drives them combinationally from the FIX stage and removes the DONE cycle.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- en  in  1  start request; accepted only when ready=1
- uns  in  1  1 = unsigned divide, 0 = two's-complement divide; sampled with en
- a  in  DWIDTH  dividend (Pu_types::Word)
- b  in  DWIDTH  divisor (Pu_types::Word)
- ready  out  1  idle, can accept
- complete  out  1  one-cycle pulse: results valid
- quotient  out  DWIDTH  quotient (Pu_types::Word)
- remainder  out  DWIDTH  remainder (Pu_types::Word)
- crf  out  4  Pu_types::Cr_field {lt,gt,eq,ov} for the quotient

Interface decision: one clock, clk; reset is asynchronous and active-high, port name reset.

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, complete=0, quotient=0, remainder=0, crf=0, iteration counter=0. An in-flight operation is discarded and no complete pulse follows.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE. DONE exists only when REGISTER_RESULT=1.
- IDLE:
  - ready=1.
  - On en=1, latch uns, the negate flags and abs(a)/abs(b); abs is skipped when uns=1.
  - neg_q = ~uns & (a[MSB]^b[MSB]); neg_r = ~uns & a[MSB].
  - Clear the partial remainder, set counter=DWIDTH-1, go to CALC.
- CALC:
  - ready=0. One restoring step per cycle: shift {prem,dividend} left by 1, trial-subtract the divisor on DWIDTH+1 bits, set the quotient bit if the result is non-negative.
  - Stay for exactly DWIDTH cycles, counting down to 0, then go to FIX.
- FIX:
  - Negate the quotient if neg_q; negate the remainder if neg_r. The quotient truncates toward zero and the remainder takes the sign of the dividend.
  - Compute crf, then go to DONE (or IDLE with complete=1 when REGISTER_RESULT=0).
- DONE:
  - Register the results; complete=1 for this cycle only; ready=0. Next state IDLE.
- Latency:
  - Accept cycle = cycle 0, CALC = cycles 1..DWIDTH, FIX = DWIDTH+1, complete=1 in cycle DWIDTH+2 (34 for DWIDTH=32).
  - With REGISTER_RESULT=0, complete=1 in cycle DWIDTH+1.
  - Latency is fixed for all operands, including the special cases below.
- Back-to-back: ready=1 in the cycle after complete. en in that cycle is accepted.
- en while ready=0 is ignored, not queued. a, b and uns may change freely after acceptance.
- Outputs hold their last values from the complete cycle until the next complete.
- crf:
  - lt/gt/eq classify the final quotient as a signed value (also when uns=1): exactly one of the three is set.
  - ov=1 on divide-by-zero (b=0) or on signed overflow (uns=0, a=0x8000_0000, b=0xFFFF_FFFF); ov=0 otherwise.
- Divide-by-zero results: quotient=0, remainder=a (unmodified), crf.eq=1, crf.ov=1.
- Signed overflow results: quotient=0x8000_0000, remainder=0, crf.lt=1, crf.ov=1. The natural datapath already gives these values; ov is forced.
- Assertions (bench): complete never high in two consecutive cycles; ready and complete never both high.

Test Plan:
- Signed 100/7: en=1, a=100, b=7, uns=0 -> complete in cycle 34, quotient=14, remainder=2, crf.gt=1, ov=0.
- Signed -100/7 (a=0xFFFF_FF9C, b=7) -> quotient=0xFFFF_FFF2 (-14), remainder=0xFFFF_FFFE (-2), crf.lt=1. Also 100/-7 -> quotient=-14, remainder=+2.
- Unsigned 0xFFFF_FFFF/2, uns=1 -> quotient=0x7FFF_FFFF, remainder=1, crf.gt=1. The same operands with uns=0 (-1/2) -> quotient=0, remainder=0xFFFF_FFFF, crf.eq=1.
- Special cases:
  - a=0x1234, b=0 -> quotient=0, remainder=0x1234, crf={eq,ov}, still at cycle 34.
  - a=0x8000_0000, b=0xFFFF_FFFF, uns=0 -> quotient=0x8000_0000, remainder=0, crf={lt,ov}.
- Handshake:
  - Hold en=1 continuously with changing operands: only operands present when ready=1 are computed, and complete pulses every 35 cycles.
  - Apply reset at cycle 10 of an operation: all outputs 0 and ready=1 immediately; no complete pulse follows.
  - The next operation after reset (50/5) -> quotient=10, remainder=0.
